lut_config_loader: RTL and testbench



---
 rtl/lut_config_pkg.sv | 14 +
 rtl/lut_config_serializer.sv | 36 +++
 rtl/lut_config_loader.sv | 157 +++++++++++++++
 tb/tb_lut_config_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lut_config_pkg.sv
// Shared types and default sizing for the LUT configuration loader.
package lut_config_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    localparam int unsigned LUT_CONFIG_BITS = 20;  // 16 truth-table + 4 selector bits
    localparam int unsigned WORD_WIDTH      = 16;
    localparam int unsigned LUTS_PER_TILE   = 4;

endpackage

// File: rtl/lut_config_serializer.sv
// Parallel-load, MSB-first shift register with a count of bits still to emit.
module lut_config_serializer #(
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned BIT_W      = $clog2(WORD_WIDTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_load,
    input  logic [WORD_WIDTH-1:0] i_word,
    input  logic [BIT_W-1:0]      i_bits,
    input  logic                  i_shift,
    output logic                  o_bit_out,
    output logic [BIT_W-1:0]      o_bits_in_word
);

    logic [WORD_WIDTH-1:0] r_shreg;
    logic [BIT_W-1:0]      r_bits;

    // A load wins over a shift: the outgoing last bit is taken from the old MSB this cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shreg <= '0;
            r_bits  <= '0;
        end else if (i_load) begin
            r_shreg <= i_word;
            r_bits  <= i_bits;
        end else if (i_shift && (r_bits != '0)) begin
            r_shreg <= {r_shreg[WORD_WIDTH-2:0], 1'b0};
            r_bits  <= r_bits - BIT_W'(1);
        end
    end

    assign o_bit_out      = r_shreg[WORD_WIDTH-1];
    assign o_bits_in_word = r_bits;

endmodule

// File: rtl/lut_config_loader.sv
// Streams host words onto the tile configuration chain, CHAIN_LENGTH bits per pass.
// Optional trailing checksum word check: define LUT_CONFIG_LOADER_CHECKSUM_EN.
module lut_config_loader #(
    parameter int unsigned WORD_WIDTH   = lut_config_pkg::WORD_WIDTH,
    parameter int unsigned CHAIN_LENGTH = lut_config_pkg::LUTS_PER_TILE
                                          * lut_config_pkg::LUT_CONFIG_BITS,
    parameter int unsigned CNT_W        = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  config_out,
    output logic                  config_enable,
    output logic                  config_busy,
    output logic                  config_done,
    output logic                  config_error
);

    import lut_config_pkg::*;

    localparam int unsigned BIT_W = $clog2(WORD_WIDTH + 1);

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_remaining, w_remaining_d;
    logic [CNT_W-1:0] w_unloaded;
    logic             r_done, w_done_d;
    logic [BIT_W-1:0] w_bits_in_word;
    logic [BIT_W-1:0] w_load_bits;
    logic             w_bit_out;
    logic             w_shift;
    logic             w_chain_ready;
    logic             w_chain_hs;
    logic             w_ready;

    // Bits of the pass not yet loaded into the serializer.
    assign w_unloaded    = r_remaining - CNT_W'(w_bits_in_word);
    assign w_shift       = (r_state == StShift) && (w_bits_in_word != '0);
    assign w_chain_ready = (r_state == StShift) && (w_bits_in_word <= BIT_W'(1))
                           && (w_unloaded != '0);
    assign w_chain_hs    = in_valid && w_chain_ready;

    always_comb begin
        w_load_bits = BIT_W'(WORD_WIDTH);
        if (32'(w_unloaded) < WORD_WIDTH) begin
            w_load_bits = BIT_W'(w_unloaded);
        end
    end

`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
    logic [WORD_WIDTH-1:0] r_acc, w_acc_d;
    logic [WORD_WIDTH-1:0] w_mask;
    logic                  r_error, w_error_d;
    logic                  w_cks_ready;
    logic                  w_cks_hs;

    // Keep only the bits that actually reach the chain (top w_load_bits).
    assign w_mask      = ~({WORD_WIDTH{1'b1}} >> w_load_bits);
    assign w_cks_ready = (r_state == StShift) && (r_remaining == '0);
    assign w_cks_hs    = in_valid && w_cks_ready;
    assign w_ready     = w_chain_ready || w_cks_ready;
`else
    assign w_ready     = w_chain_ready;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_remaining_d = r_remaining;
        w_done_d      = r_done;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        w_acc_d       = r_acc;
        w_error_d     = r_error;
`endif
        case (r_state)
            StIdle, StDone: begin
                if (start) begin
                    w_state_d     = StShift;
                    w_remaining_d = CNT_W'(CHAIN_LENGTH);
                    w_done_d      = 1'b0;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                    w_acc_d       = '0;
                    w_error_d     = 1'b0;
`endif
                end
            end
            StShift: begin
                if (w_shift) begin
                    w_remaining_d = r_remaining - CNT_W'(1);
                end
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
                if (w_chain_hs) begin
                    w_acc_d = r_acc ^ (in_data & w_mask);
                end
                if (w_cks_hs) begin
                    w_state_d = StDone;
                    w_done_d  = (in_data == r_acc);
                    w_error_d = (in_data != r_acc);
                end
`else
                if (w_remaining_d == '0) begin
                    w_state_d = StDone;
                    w_done_d  = 1'b1;
                end
`endif
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= StIdle;
            r_remaining <= '0;
            r_done      <= 1'b0;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
            r_acc       <= '0;
            r_error     <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_d;
            r_remaining <= w_remaining_d;
            r_done      <= w_done_d;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
            r_acc       <= w_acc_d;
            r_error     <= w_error_d;
`endif
        end
    end

    lut_config_serializer #(
        .WORD_WIDTH (WORD_WIDTH),
        .BIT_W      (BIT_W)
    ) u_serializer (
        .clock          (clock),
        .reset          (reset),
        .i_load         (w_chain_hs),
        .i_word         (in_data),
        .i_bits         (w_load_bits),
        .i_shift        (w_shift),
        .o_bit_out      (w_bit_out),
        .o_bits_in_word (w_bits_in_word)
    );

    assign in_ready      = w_ready;
    assign config_enable = w_shift;
    assign config_out    = w_shift & w_bit_out;
    assign config_busy   = (r_state == StShift);
    assign config_done   = r_done;
`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
    assign config_error  = r_error;
`else
    assign config_error  = 1'b0;
`endif

endmodule

// File: tb/tb_lut_config_loader.sv
// Directed bench: default 80-bit chain plus a 20-bit chain for the partial-word case.
module tb_lut_config_loader;

`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
    localparam int CKS = 1;
`else
    localparam int CKS = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        a_start = 1'b0, a_valid = 1'b0;
    logic [15:0] a_data = '0;
    logic        a_ready, a_out, a_en, a_busy, a_done, a_err;

    logic        b_start = 1'b0, b_valid = 1'b0;
    logic [15:0] b_data = '0;
    logic        b_ready, b_out, b_en, b_busy, b_done, b_err;

    lut_config_loader dut_a (
        .clock         (clock),
        .reset         (reset),
        .start         (a_start),
        .in_data       (a_data),
        .in_valid      (a_valid),
        .in_ready      (a_ready),
        .config_out    (a_out),
        .config_enable (a_en),
        .config_busy   (a_busy),
        .config_done   (a_done),
        .config_error  (a_err)
    );

    lut_config_loader #(
        .WORD_WIDTH   (16),
        .CHAIN_LENGTH (20)
    ) dut_b (
        .clock         (clock),
        .reset         (reset),
        .start         (b_start),
        .in_data       (b_data),
        .in_valid      (b_valid),
        .in_ready      (b_ready),
        .config_out    (b_out),
        .config_enable (b_en),
        .config_busy   (b_busy),
        .config_done   (b_done),
        .config_error  (b_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    typedef struct {
        logic [79:0] words;      // five words, first word in the top 16 bits
        int          stall_at;   // word index before which valid is withheld
        int          stall_len;
        int          start_mid;  // cycle of a stray start pulse, -1 for none
        int          exp_gaps;
        int          exp_end;
    } vec_t;

    typedef struct {
        logic [79:0] bits;
        int          en_cnt;
        int          gaps;
        int          end_cyc;
        int          ready_after;
        int          out_bad;
        logic        done;
        logic        err;
    } res_t;

    // Cycle 0 is the first cycle in SHIFT; end_cyc is the first cycle busy is low again.
    task automatic run_pass(input vec_t v, input logic [15:0] cks, output res_t r);
        int wi    = 0;
        int stall = 0;
        int pend  = 0;
        bit seen  = 1'b0;
        r = '{bits: '0, en_cnt: 0, gaps: 0, end_cyc: -1, ready_after: 0, out_bad: 0,
              done: 1'b0, err: 1'b0};
        @(negedge clock);
        a_start = 1'b1;
        a_valid = 1'b0;
        @(negedge clock);
        a_start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clock);
            a_start = (cyc == v.start_mid);
            #1;
            if (!a_busy) begin
                r.end_cyc = cyc;
                r.done    = a_done;
                r.err     = a_err;
                break;
            end
            if (wi < 5) begin
                if (wi == v.stall_at && a_ready && stall < v.stall_len) begin
                    a_valid = 1'b0;
                    stall++;
                end else begin
                    a_valid = 1'b1;
                    a_data  = v.words[79-16*wi -: 16];
                end
            end else begin
                a_valid = (CKS != 0);
                a_data  = cks;
                if (a_ready && CKS == 0) r.ready_after++;
            end
            #1;
            if (a_en) begin
                r.bits = {r.bits[78:0], a_out};
                r.en_cnt++;
                if (seen) r.gaps += pend;
                pend = 0;
                seen = 1'b1;
            end else begin
                if (a_out) r.out_bad++;
                if (seen) pend++;
            end
            if (a_valid && a_ready && wi < 5) wi++;
        end
        a_valid = 1'b0;
        a_start = 1'b0;
    endtask

    function automatic logic [15:0] xor_words(input logic [79:0] w);
        logic [15:0] acc = '0;
        for (int i = 0; i < 5; i++) acc ^= w[79-16*i -: 16];
        return acc;
    endfunction

    vec_t        vecs[3];
    res_t        res;
    logic [19:0] b_bits;
    int          b_en_cnt, b_end, b_ra, bw, en30;

    initial begin
        vecs[0] = '{80'hA5A5_0001_FFFF_8000_1234, -1, 0, -1, 0, 81};
        vecs[1] = '{80'hA5A5_0001_FFFF_8000_1234,  2, 3, -1, 3, 84};
        vecs[2] = '{80'h0000_FFFF_0F0F_F00F_C3C3,  4, 1, 40, 1, 82};

        reset = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check("reset_outputs", {a_ready, a_en, a_out, a_busy, a_done, a_err}, '0);
        reset = 1'b0;

        // Valid without start must not be accepted.
        a_valid = 1'b1;
        a_data  = 16'hFFFF;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            #1;
            check($sformatf("idle_c%0d", i), {a_ready, a_en, a_done, a_busy}, '0);
        end
        a_valid = 1'b0;

        for (int i = 0; i < 3; i++) begin
            run_pass(vecs[i], xor_words(vecs[i].words), res);
            check($sformatf("v%0d_bits", i), res.bits, vecs[i].words);
            check($sformatf("v%0d_enables", i), res.en_cnt, 80);
            check($sformatf("v%0d_gaps", i), res.gaps, vecs[i].exp_gaps);
            check($sformatf("v%0d_end_cycle", i), res.end_cyc, vecs[i].exp_end + CKS);
            check($sformatf("v%0d_ready_after_last", i), res.ready_after, 0);
            check($sformatf("v%0d_out_when_idle", i), res.out_bad, 0);
            check($sformatf("v%0d_done", i), res.done, 1'b1);
            check($sformatf("v%0d_error", i), res.err, 1'b0);
        end

        // Reset after 30 shifted bits abandons the pass.
        @(negedge clock);
        a_start = 1'b1;
        @(negedge clock);
        a_start = 1'b0;
        a_valid = 1'b1;
        a_data  = 16'hFFFF;
        en30    = 0;
        for (int cyc = 0; cyc < 100 && en30 < 30; cyc++) begin
            if (cyc > 0) @(negedge clock);
            #1;
            if (a_en) en30++;
        end
        check("midreset_bits_seen", en30, 30);
        reset = 1'b1;
        @(negedge clock);
        #1;
        check("midreset_outputs", {a_ready, a_en, a_out, a_busy, a_done, a_err}, '0);
        reset   = 1'b0;
        a_valid = 1'b0;
        run_pass(vecs[0], xor_words(vecs[0].words), res);
        check("after_reset_bits", res.bits, vecs[0].words);
        check("after_reset_end", res.end_cyc, 81 + CKS);
        check("after_reset_done", res.done, 1'b1);

`ifdef LUT_CONFIG_LOADER_CHECKSUM_EN
        run_pass(vecs[0], 16'h0000, res);
        check("cks_bad_done", res.done, 1'b0);
        check("cks_bad_error", res.err, 1'b1);
        repeat (5) @(negedge clock);
        #1;
        check("cks_error_sticky", a_err, 1'b1);
        run_pass(vecs[2], xor_words(vecs[2].words), res);
        check("cks_good_done", res.done, 1'b1);
        check("cks_good_error_cleared", res.err, 1'b0);
`endif

        // 20-bit chain: only the top 4 bits of the second word reach the chain.
        @(negedge clock);
        b_start = 1'b1;
        @(negedge clock);
        b_start  = 1'b0;
        bw       = 0;
        b_bits   = '0;
        b_en_cnt = 0;
        b_end    = -1;
        b_ra     = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clock);
            #1;
            if (!b_busy) begin
                b_end = cyc;
                break;
            end
            if (bw < 2) begin
                b_valid = 1'b1;
                b_data  = (bw == 0) ? 16'hFFFF : 16'hA5C3;
            end else begin
                b_valid = (CKS != 0);
                b_data  = 16'h5FFF;
                if (b_ready && CKS == 0) b_ra++;
            end
            #1;
            if (b_en) begin
                b_bits = {b_bits[18:0], b_out};
                b_en_cnt++;
            end
            if (b_valid && b_ready && bw < 2) bw++;
        end
        b_valid = 1'b0;
        check("partial_bits", b_bits, 20'hFFFFA);
        check("partial_enables", b_en_cnt, 20);
        check("partial_end_cycle", b_end, 21 + CKS);
        check("partial_ready_after_last", b_ra, 0);
        check("partial_done", b_done, 1'b1);
        check("partial_error", b_err, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
